// File: rtl/vector_mem_pkg.sv
// Shared types, widths and helpers for the vector memory responder.
// Widths: ADDR_W RAM byte address, ELEM_W lane/RAM data, LANES lanes per vector.
package vector_mem_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned ELEM_W = 8;
  localparam int unsigned LANES  = 16;
  localparam int unsigned VEC_W  = LANES * ELEM_W;
  localparam int unsigned IDX_W  = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READ_TAIL,
    DONE
  } vmr_state_t;

  // Byte address of a lane; wraps modulo 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return ADDR_W'(base + ADDR_W'(idx));
  endfunction

  // Extract one lane from a packed vector.
  function automatic logic [ELEM_W-1:0] lane_sel(input logic [VEC_W-1:0] vec,
                                                 input logic [IDX_W-1:0] idx);
    return vec[idx*ELEM_W +: ELEM_W];
  endfunction

endpackage

// File: rtl/vector_mem_responder_if.sv
// Request/response bus between the Memory stage (master) and the responder (slave).
// master drives req_valid/req_write/req_addr/req_wdata/req_mask;
// slave drives req_ready/busy/done/resp_rdata.
interface vector_mem_responder_if;
  import vector_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [VEC_W-1:0]  req_wdata;
  logic [LANES-1:0]  req_mask;
  logic              busy;
  logic              done;
  logic [VEC_W-1:0]  resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_mask,
    input  req_ready, busy, done, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_mask,
    output req_ready, busy, done, resp_rdata
  );

endinterface

// File: rtl/vector_lane_assembler.sv
// Assembly register for load data: LANES x ELEM_W with a per-lane write enable.
// Ports: clk, reset (async active-high), we (lane write), lane (lane index),
//        din (lane data), vec (assembled vector).
module vector_lane_assembler
  import vector_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  lane,
  input  logic [ELEM_W-1:0] din,
  output logic [VEC_W-1:0]  vec
);

  // Lane write storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec <= '0;
    end else if (we) begin
      vec[lane*ELEM_W +: ELEM_W] <= din;
    end
  end

endmodule

// File: rtl/vector_mem_responder.sv
// Memory-side responder: serialises one 128-bit vector load/store into LANES
// byte accesses on a registered 8-bit RAM port.
// Ports: clk, reset (async active-high), bus (slave side of request bus),
//        ram_addr/ram_wdata/ram_wren (RAM drive), ram_rdata (RAM data, 1-cycle latency).
module vector_mem_responder
  import vector_mem_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  vector_mem_responder_if.slave   bus,
  output logic [ADDR_W-1:0]       ram_addr,
  output logic [ELEM_W-1:0]       ram_wdata,
  output logic                    ram_wren,
  input  logic [ELEM_W-1:0]       ram_rdata
);

  vmr_state_t        state, state_n;
  logic [IDX_W-1:0]  idx, idx_n, idx_inc;
  logic [ADDR_W-1:0] base_q, base_n;
  logic [VEC_W-1:0]  wdata_q, wdata_n;
  logic [LANES-1:0]  mask_q, mask_n;

  // Next values of registered outputs; every output is a function of the next state.
  logic              req_ready_n, busy_n, done_n, ram_wren_n;
  logic [ADDR_W-1:0] ram_addr_n;
  logic [ELEM_W-1:0] ram_wdata_n;
  logic [VEC_W-1:0]  resp_rdata_n;

  logic              asm_we;
  logic [IDX_W-1:0]  asm_lane;
  logic [VEC_W-1:0]  asm_vec;

  assign idx_inc = idx + IDX_W'(1);

  vector_lane_assembler u_asm (
    .clk   (clk),
    .reset (reset),
    .we    (asm_we),
    .lane  (asm_lane),
    .din   (ram_rdata),
    .vec   (asm_vec)
  );

  // Next-state, request latch and output decode.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    base_n       = base_q;
    wdata_n      = wdata_q;
    mask_n       = mask_q;
    ram_addr_n   = ram_addr;
    ram_wdata_n  = ram_wdata;
    ram_wren_n   = 1'b0;
    resp_rdata_n = bus.resp_rdata;
    asm_we       = 1'b0;
    asm_lane     = idx - IDX_W'(1);

    case (state)
      IDLE: begin
        if (bus.req_valid && bus.req_ready) begin
          base_n     = bus.req_addr;
          wdata_n    = bus.req_wdata;
          mask_n     = bus.req_mask;
          idx_n      = '0;
          ram_addr_n = bus.req_addr;
          if (bus.req_write) begin
            state_n     = WRITE;
            ram_wdata_n = lane_sel(bus.req_wdata, '0);
            ram_wren_n  = bus.req_mask[0];
          end else begin
            state_n = READ;
          end
        end
      end

      WRITE: begin
        if (idx == IDX_W'(LANES - 1)) begin
          state_n = DONE;
        end else begin
          idx_n       = idx_inc;
          ram_addr_n  = lane_addr(base_q, idx_inc);
          ram_wdata_n = lane_sel(wdata_q, idx_inc);
          ram_wren_n  = mask_q[idx_inc];
        end
      end

      READ: begin
        // RAM data trails the address by one cycle, so lane idx-1 arrives now.
        asm_we = (idx != '0);
        if (idx == IDX_W'(LANES - 1)) begin
          state_n = READ_TAIL;
        end else begin
          idx_n      = idx_inc;
          ram_addr_n = lane_addr(base_q, idx_inc);
        end
      end

      READ_TAIL: begin
        // Last lane is merged directly so the response is complete in the done cycle.
        asm_we   = 1'b1;
        asm_lane = IDX_W'(LANES - 1);
        resp_rdata_n = asm_vec;
        resp_rdata_n[VEC_W-1 -: ELEM_W] = ram_rdata;
        state_n  = DONE;
      end

      DONE: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    req_ready_n = (state_n == IDLE);
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
  end

  // State, latch and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      idx            <= '0;
      base_q         <= '0;
      wdata_q        <= '0;
      mask_q         <= '0;
      bus.req_ready  <= 1'b1;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.resp_rdata <= '0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
      ram_wren       <= 1'b0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      base_q         <= base_n;
      wdata_q        <= wdata_n;
      mask_q         <= mask_n;
      bus.req_ready  <= req_ready_n;
      bus.busy       <= busy_n;
      bus.done       <= done_n;
      bus.resp_rdata <= resp_rdata_n;
      ram_addr       <= ram_addr_n;
      ram_wdata      <= ram_wdata_n;
      ram_wren       <= ram_wren_n;
    end
  end

endmodule

// File: tb/tb_vector_mem_responder.sv
// Self-checking bench for vector_mem_responder with a registered byte RAM model
// and a reference memory/response model.
module tb_vector_mem_responder;
  import vector_mem_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              ram_clr;
  logic [ADDR_W-1:0] ram_addr;
  logic [ELEM_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [ELEM_W-1:0] ram_rdata;

  logic [7:0]   mem     [0:65535];
  logic [7:0]   ref_mem [0:65535];
  logic [127:0] last_load;

  int n_cmp  = 0;
  int n_fail = 0;

  vector_mem_responder_if bus ();

  vector_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wren  (ram_wren),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Registered RAM: read data appears one cycle after the address.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 65536; i++) mem[i] <= 8'h00;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_vec(input logic [15:0] addr);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = ref_mem[16'(addr + i)];
    return v;
  endfunction

  function automatic logic [127:0] ram_vec(input logic [15:0] addr);
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = mem[16'(addr + i)];
    return v;
  endfunction

  task automatic ref_store(input logic [15:0] addr, input logic [127:0] d, input logic [15:0] m,
                           input int lanes);
    for (int i = 0; i < lanes; i++)
      if (m[i]) ref_mem[16'(addr + i)] = d[8*i +: 8];
  endtask

  task automatic drive_req(input logic wr, input logic [15:0] addr, input logic [127:0] d,
                           input logic [15:0] m);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = d;
    bus.req_mask  = m;
  endtask

  // Wait (bounded) until ready, then consume the acceptance edge.
  task automatic accept(input string tag, output bit ok);
    int w = 0;
    while (bus.req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    ok = (w < 50);
    check({tag, "_accept"}, 128'(ok), 128'(1));
    @(posedge clk);
  endtask

  // One full request with latency, busy/ready profile, RAM-port and result checks.
  task automatic run_req(input string tag, input logic wr, input logic [15:0] addr,
                         input logic [127:0] d, input logic [15:0] m);
    int exp_lat, done_k, n_done, wren_cnt, prof_bad, port_bad;
    bit ok;
    exp_lat = wr ? 17 : 18;
    done_k = 0; n_done = 0; wren_cnt = 0; prof_bad = 0; port_bad = 0;
    @(negedge clk);
    drive_req(wr, addr, d, m);
    accept(tag, ok);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
      if (bus.done === 1'b1) begin
        n_done++;
        if (done_k == 0) done_k = k;
      end
      if (ram_wren === 1'b1) wren_cnt++;
      if (bus.busy !== 1'((k <= exp_lat) ? 1 : 0)) prof_bad++;
      if (bus.req_ready !== 1'((k > exp_lat) ? 1 : 0)) prof_bad++;
      if (k <= 16) begin
        if (ram_addr !== 16'(addr + k - 1)) port_bad++;
        if (wr) begin
          if (ram_wren !== m[k-1]) port_bad++;
          if (m[k-1] && ram_wdata !== d[8*(k-1) +: 8]) port_bad++;
        end else if (ram_wren !== 1'b0) port_bad++;
      end
    end
    check({tag, "_done_cycle"}, 128'(done_k), 128'(exp_lat));
    check({tag, "_done_count"}, 128'(n_done), 128'(1));
    check({tag, "_wren_cycles"}, 128'(wren_cnt), 128'(wr ? $countones(m) : 0));
    check({tag, "_busy_ready"}, 128'(prof_bad), 128'(0));
    check({tag, "_ram_port"}, 128'(port_bad), 128'(0));
    if (wr) begin
      ref_store(addr, d, m, 16);
      check({tag, "_ram_bytes"}, ram_vec(addr), ref_vec(addr));
    end else begin
      last_load = ref_vec(addr);
    end
    check({tag, "_resp_rdata"}, bus.resp_rdata, last_load);
  endtask

  initial begin
    logic [127:0] d, d_a, d_b;
    logic [15:0]  a;
    int           n_done, d1, d2, wr_after;
    bit           ok;

    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    last_load     = '0;
    reset         = 1'b1;
    ram_clr       = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_mask  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", 128'(bus.req_ready), 128'(1));
    check("rst_busy",  128'(bus.busy), 128'(0));
    check("rst_done",  128'(bus.done), 128'(0));
    check("rst_resp",  bus.resp_rdata, 128'(0));
    check("rst_ram",   128'({ram_addr, ram_wdata, ram_wren}), 128'(0));
    reset   = 1'b0;
    ram_clr = 1'b0;

    // Test 1: ascending byte store
    for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
    run_req("t1_store", 1'b1, 16'h0020, d, 16'hFFFF);

    // Test 2: load it back
    run_req("t2_load", 1'b0, 16'h0020, '0, 16'h0000);
    check("t2_const", bus.resp_rdata, 128'h0F0E0D0C0B0A09080706050403020100);

    // Test 3: partial-mask store over a preset region
    run_req("t3_preset", 1'b1, 16'h0040, {16{8'h55}}, 16'hFFFF);
    run_req("t3_store", 1'b1, 16'h0040, {16{8'hAA}}, 16'h00FF);
    check("t3_const", ram_vec(16'h0040), {{8{8'h55}}, {8{8'hAA}}});

    // Test 4: address wrap-around
    d = {$urandom, $urandom, $urandom, $urandom};
    run_req("t4_store", 1'b1, 16'hFFF8, d, 16'hFFFF);
    check("t4_low", ram_vec(16'h0000) & {{8{8'h00}}, {8{8'hFF}}}, 128'(d[127:64]));
    run_req("t4_load", 1'b0, 16'hFFF8, '0, 16'h0000);
    check("t4_same", bus.resp_rdata, d);

    // Test 5: request held and changed while busy
    d_a = {$urandom, $urandom, $urandom, $urandom};
    d_b = ~d_a;
    n_done = 0; d1 = 0; d2 = 0;
    @(negedge clk);
    drive_req(1'b1, 16'h0300, d_a, 16'hFFFF);
    accept("t5", ok);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) drive_req(1'b1, 16'h0300, d_b, 16'hFFFF);
      if (bus.done === 1'b1) begin
        n_done++;
        if (n_done == 1) d1 = k; else if (n_done == 2) d2 = k;
      end
      if (k == 5)  check("t5_ready_busy", 128'(bus.req_ready), 128'(0));
      if (k == 18) check("t5_ready_idle", 128'(bus.req_ready), 128'(1));
      if (k == 19) bus.req_valid = 1'b0;
    end
    check("t5_done_count", 128'(n_done), 128'(2));
    check("t5_done1", 128'(d1), 128'(17));
    check("t5_done2", 128'(d2), 128'(35));
    ref_store(16'h0300, d_a, 16'hFFFF, 16);
    ref_store(16'h0300, d_b, 16'hFFFF, 16);
    check("t5_ram", ram_vec(16'h0300), ref_vec(16'h0300));

    // Test 6: reset during the 5th write cycle
    run_req("t6_preset", 1'b1, 16'h0500, {16{8'h11}}, 16'hFFFF);
    d = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    drive_req(1'b1, 16'h0500, d, 16'hFFFF);
    accept("t6", ok);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.req_valid = 1'b0;
    end
    reset = 1'b1;
    #1;
    check("t6_rst_wren",  128'(ram_wren), 128'(0));
    check("t6_rst_ready", 128'(bus.req_ready), 128'(1));
    check("t6_rst_busy",  128'(bus.busy), 128'(0));
    check("t6_rst_resp",  bus.resp_rdata, 128'(0));
    check("t6_rst_addr",  128'({ram_addr, ram_wdata}), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    n_done = 0; wr_after = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) n_done++;
      if (ram_wren === 1'b1) wr_after++;
    end
    check("t6_no_done", 128'(n_done), 128'(0));
    check("t6_no_write", 128'(wr_after), 128'(0));
    check("t6_ready_after", 128'(bus.req_ready), 128'(1));
    ref_store(16'h0500, d, 16'hFFFF, 4);
    last_load = '0;
    check("t6_ram", ram_vec(16'h0500), ref_vec(16'h0500));
    run_req("t6_load", 1'b0, 16'h0500, '0, 16'h0000);

    // Randomized requests against the reference model
    for (int n = 0; n < 24; n++) begin
      a = (n % 3 == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF)) : 16'($urandom_range(0, 16'h07FF));
      d = {$urandom, $urandom, $urandom, $urandom};
      run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), a, d, 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
